// File: rtl/cpu_defs.sv
// Shared register-file widths and the writeback request record.
package cpu_defs;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] wa;
      logic [DATA_W-1:0]     wd;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with valid/ready push, unconditional-when-nonempty pop and an
// occupancy counter; ready reflects registered full only.
module wb_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign push_ready = !full;
   assign do_push    = push_valid && !full;
   assign do_pop     = pop && !empty;
   assign pop_data   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and buffered long-latency
// results; tracks outstanding long-latency destinations and stalls the pipe on starvation.
module rf_wb_arbiter
   import cpu_defs::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_we,
   input  logic [REG_ADDR_W-1:0] pipe_wa,
   input  logic [DATA_W-1:0]     pipe_wd,
   input  logic                  lng_valid,
   output logic                  lng_ready,
   input  logic [REG_ADDR_W-1:0] lng_wa,
   input  logic [DATA_W-1:0]     lng_wd,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_wa,
   input  logic [REG_ADDR_W-1:0] q_ra1,
   input  logic [REG_ADDR_W-1:0] q_ra2,
   output logic                  q_hazard1,
   output logic                  q_hazard2,
   output logic                  pipe_stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0]     rf_wd,
   output logic [NUM_REGS-1:0]   pending
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   wb_req_t                 lng_req;
   wb_req_t                 head;
   logic [$bits(wb_req_t)-1:0] head_bits;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pipe_grant;
   logic                    pop;
   logic [CW-1:0]           starve_cnt;
   logic [CW-1:0]           starve_nxt;
   logic [NUM_REGS-1:0]     pending_nxt;

   assign lng_req = '{we: 1'b1, wa: lng_wa, wd: lng_wd};
   assign head    = wb_req_t'(head_bits);

   wb_fifo #(.WIDTH($bits(wb_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (lng_valid),
      .push_ready (lng_ready),
      .push_data  (lng_req),
      .pop        (pop),
      .pop_data   (head_bits),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // Pipeline wins unless stalled; r0 writes count as no request.
   assign pipe_grant = !pipe_stall && pipe_we && (pipe_wa != '0);
   assign pop        = !pipe_grant && !fifo_empty;

   assign q_hazard1 = (q_ra1 != '0) && pending[q_ra1];
   assign q_hazard2 = (q_ra2 != '0) && pending[q_ra2];

   always_comb begin
      starve_nxt = starve_cnt;
      if (fifo_empty || pop)     starve_nxt = '0;
      else if (starve_cnt != LIMIT) starve_nxt = starve_cnt + 1'b1;
   end

   // Set after clear so a same-cycle issue to the committing register wins.
   always_comb begin
      pending_nxt = pending;
      if (pop && head.wa != '0)        pending_nxt[head.wa] = 1'b0;
      if (iss_valid && iss_wa != '0)   pending_nxt[iss_wa]  = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we      <= 1'b0;
         rf_wa      <= '0;
         rf_wd      <= '0;
         pending    <= '0;
         starve_cnt <= '0;
         pipe_stall <= 1'b0;
      end else begin
         pending    <= pending_nxt;
         starve_cnt <= starve_nxt;
         pipe_stall <= (starve_nxt == LIMIT);
         if (pipe_grant) begin
            rf_we <= 1'b1;
            rf_wa <= pipe_wa;
            rf_wd <= pipe_wd;
         end else if (pop) begin
            rf_we <= head.we && (head.wa != '0);
            rf_wa <= head.wa;
            rf_wd <= head.wd;
         end else begin
            rf_we <= 1'b0;
         end
      end
   end

   a_no_pipe_we_in_stall: assert property (@(posedge clk) disable iff (rst)
      pipe_stall |-> !pipe_we);
endmodule
